// File: rtl/ah_mux_pkg.sv
// ah_mux_pkg: shared widths and arbiter state encoding for the round-robin packet mux.
`default_nettype none
package ah_mux_pkg;

  localparam int DATA_W  = 36;
  localparam int NUM_ING = 27;
  localparam int SEL_W   = 5;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ah_rr_arb.sv
// ah_rr_arb: rotating first-valid search starting at i_ptr, wrapping from NUM_ING-1 to 0.
`default_nettype none
module ah_rr_arb #(
  parameter int NUM_ING = ah_mux_pkg::NUM_ING,
  parameter int SEL_W   = ah_mux_pkg::SEL_W
) (
  input  logic [NUM_ING-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_vld
);

  // Scan from the farthest offset down so the nearest requester to i_ptr wins.
  always_comb begin
    int pos;
    o_vld = 1'b0;
    o_idx = '0;
    pos   = 0;
    for (int k = NUM_ING - 1; k >= 0; k--) begin
      pos = (int'(i_ptr) + k) % NUM_ING;
      if (i_req[pos]) begin
        o_vld = 1'b1;
        o_idx = SEL_W'(pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ah_rr_mux_36_27.sv
// ah_rr_mux_36_27: packet-locked round-robin N:1 mux with a single registered egress stage.
`default_nettype none
module ah_rr_mux_36_27 #(
  parameter int DATA_W  = ah_mux_pkg::DATA_W,
  parameter int NUM_ING = ah_mux_pkg::NUM_ING,
  parameter int SEL_W   = ah_mux_pkg::SEL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_ING*DATA_W-1:0] ing_data,
  input  logic [NUM_ING-1:0]        ing_last,
  input  logic [NUM_ING-1:0]        ing_valid,
  output logic [NUM_ING-1:0]        ing_ready,
  output logic [DATA_W-1:0]         egr_data,
  output logic                      egr_last,
  output logic [SEL_W-1:0]          egr_src,
  output logic                      egr_valid,
  input  logic                      egr_ready,
  output logic [15:0]               pkt_cnt
);
  import ah_mux_pkg::*;

  state_t              r_state, w_state_nxt;
  logic [SEL_W-1:0]    r_owner, w_owner_nxt;
  logic [SEL_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [SEL_W-1:0]    w_arb_idx, w_sel;
  logic                w_arb_vld, w_gnt_vld, w_load, w_acc, w_sel_last;
  logic [DATA_W-1:0]   w_sel_data;
  logic [NUM_ING-1:0]  w_ready;
  logic [DATA_W-1:0]   r_egr_data;
  logic                r_egr_last, r_egr_valid;
  logic [SEL_W-1:0]    r_egr_src;
  logic [15:0]         r_pkt_cnt;

  ah_rr_arb #(
    .NUM_ING (NUM_ING),
    .SEL_W   (SEL_W)
  ) u_arb (
    .i_req (ing_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_arb_idx),
    .o_vld (w_arb_vld)
  );

  assign w_load    = !r_egr_valid || egr_ready;
  assign w_sel     = (r_state == ST_LOCKED) ? r_owner : w_arb_idx;
  assign w_gnt_vld = (r_state == ST_LOCKED) || w_arb_vld;

  // Owner keeps its ready slot even with valid low, so the lock survives gaps.
  always_comb begin
    w_ready    = '0;
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_ING; i++) begin
      if (w_sel == SEL_W'(i)) begin
        w_sel_data = ing_data[i*DATA_W +: DATA_W];
        w_sel_last = ing_last[i];
        w_ready[i] = !rst && w_load && w_gnt_vld;
      end
    end
  end

  assign w_acc = |(w_ready & ing_valid);

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_acc) begin
      if (w_sel_last) begin
        w_state_nxt  = ST_IDLE;
        w_rr_ptr_nxt = (w_sel == SEL_W'(NUM_ING - 1)) ? '0 : w_sel + 1'b1;
      end else begin
        w_state_nxt = ST_LOCKED;
        w_owner_nxt = w_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_egr_valid <= 1'b0;
      r_egr_data  <= '0;
      r_egr_last  <= 1'b0;
      r_egr_src   <= '0;
      r_pkt_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_egr_valid <= w_acc;
        if (w_acc) begin
          r_egr_data <= w_sel_data;
          r_egr_last <= w_sel_last;
          r_egr_src  <= w_sel;
        end
      end
      if (w_acc && w_sel_last && (r_pkt_cnt != 16'hFFFF)) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
    end
  end

  assign ing_ready = w_ready;
  assign egr_data  = r_egr_data;
  assign egr_last  = r_egr_last;
  assign egr_src   = r_egr_src;
  assign egr_valid = r_egr_valid;
  assign pkt_cnt   = r_pkt_cnt;

endmodule
`default_nettype wire

// File: doc/ah_rr_mux_36_27.md
AH_RR_MUX_36_27 -- requirements
Module: ah_rr_mux_36_27

Interface
REQ-001 Parameter DATA_W, default 36, sets the payload width of every ingress and egress beat.
REQ-002 Parameter NUM_ING, default 27, sets the number of ingress ports.
REQ-003 Parameter SEL_W, default 5, sets the source-index width and SHALL satisfy 2**SEL_W >= NUM_ING.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 ing_data  in  NUM_ING*DATA_W  packed payloads; port i occupies bits [i*DATA_W +: DATA_W].
REQ-008 ing_last  in  NUM_ING  bit i marks the final beat of port i's packet.
REQ-009 ing_valid  in  NUM_ING  bit i indicates port i presents a beat.
REQ-010 ing_ready  out  NUM_ING  bit i indicates port i's beat is accepted this cycle.
REQ-011 egr_data  out  DATA_W  registered payload.
REQ-012 egr_last  out  1  registered last-beat flag.
REQ-013 egr_src  out  SEL_W  index of the ingress port that supplied the current egress beat.
REQ-014 egr_valid  out  1  egress beat valid.
REQ-015 egr_ready  in  1  downstream accepts the egress beat.
REQ-016 pkt_cnt  out  16  count of completed packets; saturates at 16'hFFFF.

Function
REQ-017 A transfer on any port SHALL occur only in a cycle in which both valid and ready are 1.
REQ-018 Define load = !egr_valid | egr_ready; the egress register SHALL load only when load = 1.
REQ-019 At most one ing_ready bit SHALL be 1 in any cycle.
REQ-020 No ing_ready bit SHALL be 1 when load = 0.
REQ-021 ing_ready SHALL NOT depend combinationally on ing_valid of a non-granted port.
REQ-022 States: IDLE (no owner) and LOCKED (owner register holds a port index).
REQ-023 In IDLE, the grant SHALL go to the first port i with ing_valid[i]=1, searching from rr_ptr upward with wrap-around from NUM_ING-1 to 0.
REQ-024 In LOCKED, only ing_ready[owner] SHALL be assertable; all other valid ports SHALL stall.
REQ-025 IDLE->LOCKED SHALL occur when a granted beat with last=0 is accepted; owner SHALL be set to that port.
REQ-026 LOCKED->IDLE SHALL occur when the owner's last=1 beat is accepted.
REQ-027 On every accepted last=1 beat from port p, rr_ptr SHALL become p+1, or 0 when p = NUM_ING-1.
REQ-028 A single-beat packet accepted in IDLE SHALL leave the state IDLE and SHALL update rr_ptr.
REQ-029 On each accepted beat, egr_data, egr_last and egr_src SHALL take the granted port's data, last flag and index, and egr_valid SHALL be 1 on the next cycle.
REQ-030 If load = 1 and no beat is accepted, egr_valid SHALL be 0 on the next cycle.
REQ-031 While egr_valid = 1 and egr_ready = 0, egr_data, egr_last and egr_src SHALL hold stable.
REQ-032 Ingress-to-egress latency SHALL be 1 cycle, and throughput SHALL be 1 beat per cycle when egr_ready is held at 1.
REQ-033 pkt_cnt SHALL increment by 1 on each accepted ingress beat with last=1, and SHALL hold at 16'hFFFF once reached.
REQ-034 A port that drops valid while it is owner SHALL keep the lock; no other port is granted until its last beat.

Reset
REQ-035 While rst = 1 at a rising clk edge, the block SHALL reset to: state IDLE, owner 0, rr_ptr 0, egr_valid 0, egr_data 0, egr_last 0, egr_src 0, pkt_cnt 0.
REQ-036 While rst = 1, all ing_ready bits SHALL be 0.
REQ-037 A reset asserted mid-packet SHALL abandon the lock and the in-flight egress beat, with no partial beat presented after reset.

Structure
REQ-038 DATA_W, NUM_ING, SEL_W and the IDLE/LOCKED state enumeration SHALL reside in shared package ah_mux_pkg.
REQ-039 The rotating first-valid search SHALL be a sub-module ah_rr_arb (inputs: request vector, rr_ptr; outputs: grant index, grant valid).

Verification
REQ-040 Reset check: hold rst for 2 cycles with all ing_valid=1 -> ing_ready=0, egr_valid=0, pkt_cnt=0 throughout.
REQ-041 Round-robin: ports 0, 5 and 26 each send single-beat packets continuously with egr_ready=1 -> egr_src sequence 0, 5, 26, 0, 5, 26, with a beat every cycle.
REQ-042 Lock: port 3 sends a 4-beat packet while port 4 is valid -> egr_src=3 for 4 consecutive beats, then 4; pkt_cnt increments by 1 after the 4th beat.
REQ-043 Backpressure: egr_ready=0 for 5 cycles mid-packet -> egr_data stable, ing_ready all 0 while egr_valid=1, and no beat lost or duplicated.
REQ-044 Wrap: rr_ptr=26 with ports 26 and 1 valid -> grant order 26 then 1.
REQ-045 Reset mid-packet: assert rst on the 2nd beat of a 3-beat packet from port 7 -> state IDLE, and port 2 is granted first afterwards when ports 2 and 7 are valid.
